dff_meta_sync: RTL and testbench
================================

DFF_META_SYNC -- requirements
Module: dff_meta_sync

Interface
REQ-001 The module SHALL have parameter STAGES, default 2, giving the number of synchronizer flops (legal range 2..4).
REQ-002 The module SHALL have parameter RESET_VAL, default 1'b0, giving the value every synchronizer flop takes on reset.
REQ-003 The module SHALL have port clk, input, 1 bit: destination-domain clock; all flops update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port D, input, 1 bit: asynchronous input level, may toggle at any time relative to clk.
REQ-006 The module SHALL have port Q, output, 1 bit: synchronized level of D.
REQ-007 The module SHALL have port Q_pulse, output, 1 bit: one-clk pulse on each rising edge of Q.

Function
REQ-008 The module SHALL sample D into a chain of STAGES flops; Q SHALL be the last stage, with no combinational path from D to Q.
REQ-009 Latency: a D change stable across rising edge n SHALL appear on Q after edge n+STAGES-1 (edge n+1 for STAGES=2).
REQ-010 The module SHALL register Q once more into q_prev.
REQ-011 Q_pulse SHALL equal Q AND NOT q_prev, driven only by registered signals so it is glitch-free.
REQ-012 Q_pulse SHALL be high for exactly one clk cycle, in the cycle Q first reads 1 after being 0.
REQ-013 Q held high for many cycles SHALL produce one pulse only; a falling edge of Q SHALL produce no pulse.
REQ-014 A D high pulse too short to be captured at any rising edge MAY be lost; no pulse stretching is required.
REQ-015 A D high pulse captured at one edge only SHALL produce exactly one Q high cycle and one Q_pulse.
REQ-016 Back-to-back D toggles every cycle SHALL appear on Q delayed but otherwise unchanged, with a Q_pulse on every Q rise.
REQ-017 With reset tied low, the module SHALL still operate, so it can synchronize a reset signal itself.

Reset
REQ-018 While reset is high, all synchronizer flops SHALL be RESET_VAL immediately (asynchronously) and q_prev SHALL equal RESET_VAL.
REQ-019 While reset is high, Q SHALL read RESET_VAL and Q_pulse SHALL read 0.
REQ-020 With RESET_VAL=1, q_prev SHALL also reset to 1, so no spurious Q_pulse occurs on reset release.
REQ-021 Reset asserted mid-pulse SHALL terminate Q_pulse immediately.
REQ-022 After reset release, the first Q change SHALL follow REQ-009 timing, counted from the first rising edge after release.

Structure
REQ-023 The design SHALL be a single module with no sub-modules: a flop chain plus an edge-detect flop.
REQ-024 No shared package is required; STAGES range checking SHALL be an elaboration-time assertion inside the module.
REQ-025 Synchronizer flops SHALL carry the tool attribute marking them asynchronous-register/no-retime, and SHALL NOT be shift-register-inferred.
REQ-026 Legacy names DFF_META (D, Q only) and DFF_METAP (Q_pulse only) SHALL be thin wrappers instantiating dff_meta_sync with STAGES=2, RESET_VAL=0.

Verification
REQ-027 The bench SHALL cover: reset high, D=1 -> Q=0 and Q_pulse=0 throughout; reset low -> Q=1 at the 2nd rising edge, Q_pulse=1 for that single cycle.
REQ-028 The bench SHALL cover: D held high for 20 cycles then low -> exactly one Q_pulse; Q falls 2 edges after D falls; no pulse on the fall.
REQ-029 The bench SHALL cover: D toggling 1,0,1,0 each cycle -> Q repeats the pattern 2 edges late; Q_pulse count = 2.
REQ-030 The bench SHALL cover: reset asserted between clk edges while Q_pulse=1 -> Q and Q_pulse drop before the next edge.
REQ-031 The bench SHALL cover: RESET_VAL=1 with D=1 across reset release -> Q stays 1 and Q_pulse is never asserted.
REQ-032 The bench SHALL cover: reset tied 0, D from an unrelated clock (e.g. 100 MHz D-clock, 37 MHz clk), 1000 toggles of at least 3 clk periods each -> Q rise count = Q_pulse count = D rise count.

Source files
------------

// File: rtl/dff_meta_sync_pkg.sv
// Shared constants for the dff_meta_sync synchronizer family.
package dff_meta_sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  function automatic bit stages_ok(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/DFF_META.sv
// Legacy two-flop level synchronizer: exposes only the synchronized level.
module DFF_META (
  input  logic clk,
  input  logic reset,
  input  logic D,
  output logic Q
);

  logic q_sync;
  logic q_rise;

  dff_meta_sync #(
    .STAGES   (2),
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .D      (D),
    .Q      (q_sync),
    .Q_pulse(q_rise)
  );

  // A rise pulse only ever coincides with Q high, so OR-ing it in leaves Q unchanged.
  assign Q = q_sync | q_rise;

endmodule

// File: rtl/DFF_METAP.sv
// Legacy two-flop synchronizer: exposes only the rising-edge pulse.
module DFF_METAP (
  input  logic clk,
  input  logic reset,
  input  logic D,
  output logic Q_pulse
);

  logic q_sync;
  logic q_rise;

  dff_meta_sync #(
    .STAGES   (2),
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .D      (D),
    .Q      (q_sync),
    .Q_pulse(q_rise)
  );

  // The pulse is only ever high while Q is high, so the AND leaves it unchanged.
  assign Q_pulse = q_rise & q_sync;

endmodule

// File: rtl/dff_meta_sync.sv
// Multi-flop level synchronizer for an asynchronous input, with a glitch-free
// single-cycle pulse on every rising edge of the synchronized level.
module dff_meta_sync
  import dff_meta_sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic D,
  output logic Q,
  output logic Q_pulse
);

  if (!stages_ok(STAGES)) begin : g_stages_check
    $error("dff_meta_sync: STAGES=%0d outside legal range %0d..%0d",
           STAGES, STAGES_MIN, STAGES_MAX);
  end

  // Kept together as one placed cluster and never folded into an SRL or retimed.
  (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
  logic [STAGES-1:0] sync_chain;
  logic              q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= {STAGES{RESET_VAL}};
    end else begin
      sync_chain <= {sync_chain[STAGES-2:0], D};
    end
  end

  // q_prev resets to the same value as the chain so reset release never pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_prev <= RESET_VAL;
    end else begin
      q_prev <= sync_chain[STAGES-1];
    end
  end

  assign Q       = sync_chain[STAGES-1];
  assign Q_pulse = sync_chain[STAGES-1] & ~q_prev;

endmodule

// File: tb/tb_dff_meta_sync.sv
// Randomized bench for dff_meta_sync and its legacy wrappers, checked against a
// sampled-history reference model, plus a free-running cross-clock count test.
module tb_dff_meta_sync;

  logic clk = 1'b0;
  logic reset;
  logic d;
  logic qa, pa, qb, pb, qc, pc, ql, pl;

  logic clk_x = 1'b0;
  logic dclk = 1'b0;
  logic d_x;
  logic qx, px;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: D values sampled at each rising edge since reset release.
  logic hist[$];
  logic prev_a, prev_b, prev_c;
  int   cnt_pa, cnt_pb;

  logic x_en = 1'b0;
  logic qx_seen = 1'b0;
  int   x_q_rises = 0;
  int   x_pulses = 0;
  int   x_d_rises = 0;

  always #5 clk = ~clk;
  always #13 clk_x = ~clk_x;
  initial begin
    #2;
    forever #5 dclk = ~dclk;
  end

  dff_meta_sync #(.STAGES(2), .RESET_VAL(1'b0)) u_a (
    .clk(clk), .reset(reset), .D(d), .Q(qa), .Q_pulse(pa));
  dff_meta_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_b (
    .clk(clk), .reset(reset), .D(d), .Q(qb), .Q_pulse(pb));
  dff_meta_sync #(.STAGES(3), .RESET_VAL(1'b0)) u_c (
    .clk(clk), .reset(reset), .D(d), .Q(qc), .Q_pulse(pc));
  DFF_META  u_lm (.clk(clk), .reset(reset), .D(d), .Q(ql));
  DFF_METAP u_lp (.clk(clk), .reset(reset), .D(d), .Q_pulse(pl));
  dff_meta_sync #(.STAGES(2), .RESET_VAL(1'b0)) u_x (
    .clk(clk_x), .reset(1'b0), .D(d_x), .Q(qx), .Q_pulse(px));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic logic model_q(input int stages, input logic rv);
    int n;
    n = hist.size();
    return (n >= stages) ? hist[n - stages] : rv;
  endfunction

  task automatic model_reset();
    hist.delete();
    prev_a = 1'b0;
    prev_b = 1'b1;
    prev_c = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic ea, eb, ec;
    ea = model_q(2, 1'b0);
    eb = model_q(2, 1'b1);
    ec = model_q(3, 1'b0);
    check_eq({tag, ".a_q"}, 32'(qa), 32'(ea));
    check_eq({tag, ".a_p"}, 32'(pa), 32'(ea & ~prev_a));
    check_eq({tag, ".b_q"}, 32'(qb), 32'(eb));
    check_eq({tag, ".b_p"}, 32'(pb), 32'(eb & ~prev_b));
    check_eq({tag, ".c_q"}, 32'(qc), 32'(ec));
    check_eq({tag, ".c_p"}, 32'(pc), 32'(ec & ~prev_c));
    check_eq({tag, ".lm_q"}, 32'(ql), 32'(ea));
    check_eq({tag, ".lp_p"}, 32'(pl), 32'(ea & ~prev_a));
    cnt_pa += int'(pa);
    cnt_pb += int'(pb);
    prev_a = ea;
    prev_b = eb;
    prev_c = ec;
  endtask

  // One clk cycle: drive at the falling edge (optionally with an uncapturable
  // opposite-level glitch), record the sample at the rising edge, check after it.
  task automatic tick(input logic nd, input logic nr, input logic glitch);
    @(negedge clk);
    reset = nr;
    if (nr) model_reset();
    if (glitch) begin
      d = ~nd;
      #2;
      d = nd;
    end else begin
      d = nd;
    end
    @(posedge clk);
    if (!reset) hist.push_back(d);
    #1;
    check_all("tick");
  endtask

  always @(negedge clk_x) begin
    if (x_en) begin
      if (qx && !qx_seen) x_q_rises++;
      if (px) x_pulses++;
    end
    qx_seen = qx;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog @%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic nr, nd, gl;
    reset = 1'b1;
    d = 1'b1;
    d_x = 1'b0;
    model_reset();
    cnt_pa = 0;
    cnt_pb = 0;

    // Reset held with D high: every output sits at its reset value.
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check_eq("rst_a_q", 32'(qa), 32'd0);
    check_eq("rst_a_p", 32'(pa), 32'd0);
    check_eq("rst_b_q", 32'(qb), 32'd1);
    cnt_pa = 0;
    cnt_pb = 0;

    // Release: Q rises at the second edge with a single pulse.
    tick(1'b1, 1'b0, 1'b0);
    check_eq("rel_e1_q", 32'(qa), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("rel_e2_q", 32'(qa), 32'd1);
    check_eq("rel_e2_p", 32'(pa), 32'd1);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("rel_e3_p", 32'(pa), 32'd0);
    repeat (17) tick(1'b1, 1'b0, 1'b0);
    check_eq("rv1_b_q", 32'(qb), 32'd1);
    check_eq("rv1_b_pulses", 32'(cnt_pb), 32'd0);

    // D falls after a long high: Q follows two edges later, no pulse.
    tick(1'b0, 1'b0, 1'b0);
    check_eq("fall_e1_q", 32'(qa), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("fall_e2_q", 32'(qa), 32'd0);
    check_eq("fall_e2_p", 32'(pa), 32'd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check_eq("hold_pulses", 32'(cnt_pa), 32'd1);

    // Toggle every cycle, then an uncapturable glitch.
    cnt_pa = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check_eq("toggle_pulses", 32'(cnt_pa), 32'd2);

    // Reset asserted mid-cycle while the pulse is high.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("mid_pre_p", 32'(pa), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_a_q", 32'(qa), 32'd0);
    check_eq("mid_a_p", 32'(pa), 32'd0);
    check_eq("mid_b_q", 32'(qb), 32'd1);
    model_reset();
    check_all("mid");
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    cnt_pb = 0;
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    check_eq("rv1_b_pulses2", 32'(cnt_pb), 32'd0);

    // Randomized traffic with occasional resets and glitches.
    for (int i = 0; i < 400; i++) begin
      nr = reset ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
      nd = ($urandom_range(0, 2) == 0) ? ~d : d;
      gl = ($urandom_range(0, 9) == 0);
      tick(nd, nr, gl);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0);

    // Cross-clock run with reset tied low: every D rise yields one Q rise and one pulse.
    repeat (12) @(posedge clk_x);
    x_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(9, 20)) @(posedge dclk);
      d_x = ~d_x;
      if (d_x) x_d_rises++;
    end
    repeat (12) @(posedge clk_x);
    x_en = 1'b0;
    check_eq("xclk_q_rises", 32'(x_q_rises), 32'(x_d_rises));
    check_eq("xclk_pulses", 32'(x_pulses), 32'(x_d_rises));
    check_eq("xclk_final_q", 32'(qx), 32'(d_x));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
